// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 encodings, FSM states, lane widths.
// No logic; used by lsu_align and lsu_mem_if.
// No flow control of its own.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANE_W = 2;   // byte lane select within a 32-bit word
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, lane merge for sub-word stores.
// Purely combinational, zero latency.
// No flow control; callers supply an already-legalised funct3 and aligned lane.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [LANE_W-1:0] i_lane,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_word,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_load,
    output logic [31:0]       o_merge
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    // Pick the addressed byte and halfword out of the memory word.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extend the selected lane to 32 bits according to the access type.
    always_comb begin
        o_load = i_word;
        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load = {24'b0, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load = {16'b0, w_half};
            default: o_load = i_word;
        endcase
    end

    // Replace the addressed lane of the old word with the store data.
    always_comb begin
        o_merge = i_word;
        case (i_funct3)
            F3_B: begin
                case (i_lane)
                    2'd0: o_merge[7:0]   = i_wdata[7:0];
                    2'd1: o_merge[15:8]  = i_wdata[7:0];
                    2'd2: o_merge[23:16] = i_wdata[7:0];
                    2'd3: o_merge[31:24] = i_wdata[7:0];
                    default: o_merge = i_word;
                endcase
            end
            F3_H: begin
                if (i_lane[1]) begin
                    o_merge[31:16] = i_wdata[15:0];
                end else begin
                    o_merge[15:0] = i_wdata[15:0];
                end
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit between execute stage and a word-addressed async-read data memory.
// Loads and SW respond 1 cycle after accept; SB/SH do read-modify-write and respond after 2.
// req_ready is low during the RMW write cycle; a held request is taken the cycle after.
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of being force-aligned.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int WORD_AW = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 w_legal;
    logic [2:0]           w_f3;
    logic                 w_is_word;
    logic                 w_is_half;
    logic                 w_sub_store;
    logic                 w_trap;
    logic [LANE_W-1:0]    w_lane;
    logic [WORD_AW-1:0]   w_req_idx;
    logic [31:0]          w_load;
    logic [31:0]          w_merge;
    logic                 w_resp_now;
    logic                 w_go_rmw;
    logic                 w_unused_addr;

    logic [WORD_AW-1:0]   r_rmw_idx;
    logic [31:0]          r_merge;
    logic                 r_resp_valid;
    logic                 r_resp_err;
    logic [31:0]          r_resp_rdata;

    // Illegal encodings fall back to a full-word access and flag an error.
    assign w_legal     = f3_legal(req_we, req_funct3);
    assign w_f3        = w_legal ? req_funct3 : F3_W;
    assign w_is_word   = (w_f3 == F3_W);
    assign w_is_half   = (w_f3[1:0] == 2'b01);
    assign w_sub_store = req_we & ~w_is_word;

    // Upper address bits alias onto the memory; they are deliberately dropped.
    assign w_req_idx     = req_addr[WORD_AW+1:2];
    assign w_unused_addr = ^req_addr[31:WORD_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = (w_is_word & (req_addr[1:0] != 2'b00)) | (w_is_half & req_addr[0]);
`else
    assign w_trap = 1'b0;
`endif

    // Lane forced to natural alignment; a trapped access never uses it.
    always_comb begin
        w_lane = req_addr[1:0];
        if (w_is_word) begin
            w_lane = 2'b00;
        end else if (w_is_half) begin
            w_lane[0] = 1'b0;
        end
    end

    lsu_align u_align (
        .i_lane   (w_lane),
        .i_funct3 (w_f3),
        .i_word   (mem_rdata),
        .i_wdata  (req_wdata),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    // Next state, handshake and memory port drive; the write strobe is killed during reset.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_resp_now  = 1'b0;
        w_go_rmw    = 1'b0;
        mem_addr    = {{(32-WORD_AW){1'b0}}, w_req_idx};
        mem_wdata   = req_wdata;
        mem_we      = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_trap) begin
                        w_resp_now = 1'b1;
                    end else if (w_sub_store) begin
                        w_go_rmw    = 1'b1;
                        w_state_nxt = RMW_WR;
                    end else begin
                        w_resp_now = 1'b1;
                        mem_we     = req_we;
                    end
                end
            end
            RMW_WR: begin
                mem_addr    = {{(32-WORD_AW){1'b0}}, r_rmw_idx};
                mem_wdata   = r_merge;
                mem_we      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!rst) begin
            mem_we = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture word index and merged word for the RMW write cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rmw_idx <= '0;
            r_merge   <= '0;
        end else if (w_go_rmw) begin
            r_rmw_idx <= w_req_idx;
            r_merge   <= w_merge;
        end
    end

    // Response pulse; load data is kept until the next response, stores report zero,
    // a trapped access leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_resp_now | (r_state == RMW_WR);
            r_resp_err   <= w_resp_now & (~w_legal | w_trap);
            if (w_resp_now && !w_trap) begin
                r_resp_rdata <= req_we ? 32'h0 : w_load;
            end else if (r_state == RMW_WR) begin
                r_resp_rdata <= 32'h0;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int we_total = 0;

    always #5 clk = ~clk;

    lsu_mem_if #(.WORD_AW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    // Data memory: 64 words, async read, write on posedge.
    logic [31:0] mem [64];
    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr[5:0]] <= mem_wdata;
    end
    always @(negedge clk) begin
        if (mem_we === 1'b1) we_total <= we_total + 1;
    end

    // Reference model: byte-addressed memory plus last reported read data.
    logic [7:0]  ref_b [256];
    logic [31:0] ref_rdata;

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] e_rd,
                         output logic e_err, output int e_lat, output int e_wr);
        logic       legal;
        logic [2:0] eff;
        int         size;
        int         a;
        longint     v;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        eff   = legal ? f3 : 3'd2;
        size  = 1 << eff[1:0];
        a     = int'(addr[7:0]);
        e_err = !legal;
        e_lat = 1;
        e_wr  = 0;
        if (a % size != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            e_err = 1'b1;
            e_rd  = ref_rdata;
            return;
`else
            a = a - (a % size);
`endif
        end
        if (we) begin
            for (int k = 0; k < size; k++) ref_b[a+k] = wdata[8*k +: 8];
            e_wr      = 1;
            e_lat     = (size < 4) ? 2 : 1;
            ref_rdata = 32'h0;
        end else begin
            v = 0;
            for (int k = 0; k < size; k++) v = v + (longint'(ref_b[a+k]) << (8*k));
            if (!eff[2] && v >= (64'sd1 << (8*size-1))) v = v - (64'sd1 << (8*size));
            ref_rdata = v[31:0];
        end
        e_rd = ref_rdata;
    endtask

    // One request through the DUT; reports response data, error, latency and write count.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd,
                       output logic er, output int lat, output int wr);
        int wait_n;
        int wr0;
        wr0        = we_total;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        wait_n     = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && wait_n < 8) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            errors++;
        end
        checks++;
        if (mem_addr !== {26'b0, addr[7:2]}) begin
            $display("FAIL mem_addr_index: got %h required %h", mem_addr, {26'b0, addr[7:2]});
            errors++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        wr = we_total - wr0;
    endtask

    logic [31:0] rd, e_rd;
    logic        er, e_err;
    int          lat, e_lat, wr, e_wr;

    task automatic test_reset;
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0;
        req_wdata  = 32'h12345678;
        ref_rdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0) begin $display("FAIL reset_resp_valid: got %b required 0", resp_valid); errors++; end
        checks++; if (resp_err !== 1'b0) begin $display("FAIL reset_resp_err: got %b required 0", resp_err); errors++; end
        checks++; if (resp_rdata !== 32'h0) begin $display("FAIL reset_resp_rdata: got %h required 0", resp_rdata); errors++; end
        checks++; if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %b required 1", req_ready); errors++; end
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we: got %b required 0", mem_we); errors++; end
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
    endtask

    task automatic test_sw_lw;
        model(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, e_rd, e_err, e_lat, e_wr);
        run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, wr);
        checks++; if (lat !== 1) begin $display("FAIL sw_latency: got %0d required 1", lat); errors++; end
        checks++; if (wr !== 1) begin $display("FAIL sw_write_cycles: got %0d required 1", wr); errors++; end
        model(1'b0, 3'b010, 32'h10, 32'h0, e_rd, e_err, e_lat, e_wr);
        run(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, wr);
        checks++; if (rd !== 32'hDEADBEEF) begin $display("FAIL lw_after_sw: got %h required deadbeef", rd); errors++; end
        checks++; if (lat !== 1) begin $display("FAIL lw_latency: got %0d required 1", lat); errors++; end
        checks++; if (wr !== 0) begin $display("FAIL lw_write_cycles: got %0d required 0", wr); errors++; end
        @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0) begin $display("FAIL resp_pulse_width: got %b required 0", resp_valid); errors++; end
    endtask

    task automatic test_sb_rmw;
        model(1'b1, 3'b010, 32'h20, 32'h11223344, e_rd, e_err, e_lat, e_wr);
        run(1'b1, 3'b010, 32'h20, 32'h11223344, rd, er, lat, wr);
        model(1'b1, 3'b000, 32'h21, 32'h000000AA, e_rd, e_err, e_lat, e_wr);
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h000000AA;
        req_valid = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0) begin
            $display("FAIL sb_accept_cycle: ready=%b we=%b required 1/0", req_ready, mem_we); errors++; end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0 || mem_we !== 1'b1) begin
            $display("FAIL sb_write_cycle: ready=%b we=%b required 0/1", req_ready, mem_we); errors++; end
        checks++; if (mem_wdata !== 32'h1122AA44 || mem_addr !== 32'd8) begin
            $display("FAIL sb_merge: wdata=%h addr=%h required 1122aa44/8", mem_wdata, mem_addr); errors++; end
        @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
            $display("FAIL sb_response: valid=%b ready=%b required 1/1", resp_valid, req_ready); errors++; end
        checks++; if (mem[8] !== 32'h1122AA44) begin $display("FAIL sb_memory: got %h required 1122aa44", mem[8]); errors++; end
    endtask

    task automatic test_sign_ext;
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h1, 32'h1, 32'h0, 32'h0};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000};
        model(1'b1, 3'b010, 32'h0, 32'h00008000, e_rd, e_err, e_lat, e_wr);
        run(1'b1, 3'b010, 32'h0, 32'h00008000, rd, er, lat, wr);
        for (int i = 0; i < 4; i++) begin
            model(1'b0, f3s[i], adrs[i], 32'h0, e_rd, e_err, e_lat, e_wr);
            run(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, wr);
            checks++; if (rd !== exps[i] || er !== 1'b0) begin
                $display("FAIL sign_ext_%0d: got %h err=%b required %h err=0", i, rd, er, exps[i]); errors++; end
        end
    endtask

    task automatic test_misalign;
        model(1'b1, 3'b010, 32'h4, 32'h11111111, e_rd, e_err, e_lat, e_wr);
        run(1'b1, 3'b010, 32'h4, 32'h11111111, rd, er, lat, wr);
        model(1'b1, 3'b010, 32'h8, 32'h22222222, e_rd, e_err, e_lat, e_wr);
        run(1'b1, 3'b010, 32'h8, 32'h22222222, rd, er, lat, wr);
        model(1'b0, 3'b010, 32'h8, 32'h0, e_rd, e_err, e_lat, e_wr);
        run(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat, wr);
        model(1'b0, 3'b010, 32'h6, 32'h0, e_rd, e_err, e_lat, e_wr);
        run(1'b0, 3'b010, 32'h6, 32'h0, rd, er, lat, wr);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (rd !== 32'h22222222 || er !== 1'b1) begin
            $display("FAIL lw_misaligned: got %h err=%b required 22222222 err=1", rd, er); errors++; end
`else
        checks++; if (rd !== 32'h11111111 || er !== 1'b0) begin
            $display("FAIL lw_misaligned: got %h err=%b required 11111111 err=0", rd, er); errors++; end
`endif
        model(1'b1, 3'b010, 32'h6, 32'hCAFEF00D, e_rd, e_err, e_lat, e_wr);
        run(1'b1, 3'b010, 32'h6, 32'hCAFEF00D, rd, er, lat, wr);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (mem[1] !== 32'h11111111 || er !== 1'b1 || wr !== 0) begin
            $display("FAIL sw_misaligned: mem=%h err=%b writes=%0d required 11111111/1/0", mem[1], er, wr); errors++; end
`else
        checks++; if (mem[1] !== 32'hCAFEF00D || er !== 1'b0 || wr !== 1) begin
            $display("FAIL sw_misaligned: mem=%h err=%b writes=%0d required cafef00d/0/1", mem[1], er, wr); errors++; end
`endif
        model(1'b0, 3'b011, 32'h8, 32'h0, e_rd, e_err, e_lat, e_wr);
        run(1'b0, 3'b011, 32'h8, 32'h0, rd, er, lat, wr);
        checks++; if (rd !== 32'h22222222 || er !== 1'b1) begin
            $display("FAIL illegal_load: got %h err=%b required 22222222 err=1", rd, er); errors++; end
        model(1'b1, 3'b100, 32'h8, 32'h33333333, e_rd, e_err, e_lat, e_wr);
        run(1'b1, 3'b100, 32'h8, 32'h33333333, rd, er, lat, wr);
        checks++; if (mem[2] !== 32'h33333333 || er !== 1'b1 || lat !== 1) begin
            $display("FAIL illegal_store: mem=%h err=%b lat=%0d required 33333333/1/1", mem[2], er, lat); errors++; end
    endtask

    task automatic test_reset_in_rmw;
        model(1'b1, 3'b010, 32'h30, 32'h55667788, e_rd, e_err, e_lat, e_wr);
        run(1'b1, 3'b010, 32'h30, 32'h55667788, rd, er, lat, wr);
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h30; req_wdata = 32'h0000BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin $display("FAIL rmw_reset_we: got %b required 0", mem_we); errors++; end
        @(posedge clk);
        #1;
        rst       = 1'b1;
        ref_rdata = 32'h0;
        checks++; if (resp_valid !== 1'b0) begin $display("FAIL rmw_reset_resp: got %b required 0", resp_valid); errors++; end
        checks++; if (req_ready !== 1'b1) begin $display("FAIL rmw_reset_ready: got %b required 1", req_ready); errors++; end
        checks++; if (mem[12] !== 32'h55667788) begin $display("FAIL rmw_reset_mem: got %h required 55667788", mem[12]); errors++; end
    endtask

    task automatic test_back_to_back;
        model(1'b1, 3'b010, 32'h40, 32'hA0B0C0D0, e_rd, e_err, e_lat, e_wr);
        run(1'b1, 3'b010, 32'h40, 32'hA0B0C0D0, rd, er, lat, wr);
        model(1'b1, 3'b001, 32'h42, 32'h00001234, e_rd, e_err, e_lat, e_wr);
        model(1'b0, 3'b010, 32'h40, 32'h0, e_rd, e_err, e_lat, e_wr);
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h42; req_wdata = 32'h00001234;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin $display("FAIL hold_not_ready: got %b required 0", req_ready); errors++; end
        @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b1) begin $display("FAIL hold_sh_resp: got %b required 1", resp_valid); errors++; end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin $display("FAIL hold_ready_again: got %b required 1", req_ready); errors++; end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== e_rd) begin
            $display("FAIL hold_lw_data: valid=%b got %h required 1/%h", resp_valid, resp_rdata, e_rd); errors++; end
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            model(1'b1, 3'b010, i*4, wd, e_rd, e_err, e_lat, e_wr);
            run(1'b1, 3'b010, i*4, wd, rd, er, lat, wr);
        end
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end
            we   = 1'($urandom_range(0, 1));
            addr = {24'($urandom), 8'($urandom)};
            wd   = $urandom;
            model(we, f3, addr, wd, e_rd, e_err, e_lat, e_wr);
            run(we, f3, addr, wd, rd, er, lat, wr);
            checks++; if (rd !== e_rd) begin $display("FAIL rand_rdata[%0d]: got %h required %h", i, rd, e_rd); errors++; end
            checks++; if (er !== e_err) begin $display("FAIL rand_err[%0d]: got %b required %b", i, er, e_err); errors++; end
            checks++; if (lat !== e_lat) begin $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, e_lat); errors++; end
            checks++; if (wr !== e_wr) begin $display("FAIL rand_writes[%0d]: got %0d required %0d", i, wr, e_wr); errors++; end
        end
        for (int w = 0; w < 64; w++) begin
            checks++;
            if (mem[w] !== {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]}) begin
                $display("FAIL rand_mem[%0d]: got %h required %h", w, mem[w],
                         {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});
                errors++;
            end
        end
    endtask

    initial begin
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rst        = 1'b0;
        test_reset;
        test_sw_lw;
        test_sb_rmw;
        test_sign_ext;
        test_misalign;
        test_reset_in_rmw;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
